cache_rd_arbiter: RTL and testbench

Shares the single cache-side read port of `axi_bridge` between the icache and the dcache. Each cache keeps its native `rd_req`/`rd_rdy`/`ret_*` protocol. The arbiter grants one requester at a time and forwards that request to the bridge. It steers the returned beats back to the granted cache and holds the grant until `ret_last`. It sits between `u_icache`/`u_dcache` and the `inst_rd_*`/`data_rd_*` side of the bridge, which frees one bridge read port.

---
 rtl/cache_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_rd_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_arbiter.sv
// Shares the single axi_bridge read port between the icache (port 0) and the dcache (port 1).
// One requester is granted at a time, and the grant is held until the bridge signals ret_last.
module cache_rd_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int LINE_BEATS = 4
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        i_rd_req,
   input  logic [2:0]  i_rd_type,
   input  logic [31:0] i_rd_addr,
   output logic        i_rd_rdy,
   output logic        i_ret_valid,
   output logic        i_ret_last,
   output logic [31:0] i_ret_data,

   input  logic        d_rd_req,
   input  logic [2:0]  d_rd_type,
   input  logic [31:0] d_rd_addr,
   output logic        d_rd_rdy,
   output logic        d_ret_valid,
   output logic        d_ret_last,
   output logic [31:0] d_ret_data,

   output logic        rd_req,
   output logic [2:0]  rd_type,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data,

   output logic        busy,
   output logic        grant,
   output logic        proto_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]  state;
   logic        last_grant;
   logic [7:0]  beat_cnt;
   logic [7:0]  exp_beats;

   logic        in_issue;
   logic        in_wait;
   logic        sel_req;
   logic [2:0]  sel_type;
   logic [31:0] sel_addr;
   logic        pick_d;
   logic [7:0]  next_cnt;
   logic [7:0]  req_beats;

   // On a tie, round-robin hands the bridge to whichever port did not finish last.
   assign pick_d    = d_rd_req && (!i_rd_req || (FIXED_PRIO != 0) || !last_grant);

   assign in_issue  = (state == ISSUE);
   assign in_wait   = (state == WAIT);
   assign sel_req   = grant ? d_rd_req  : i_rd_req;
   assign sel_type  = grant ? d_rd_type : i_rd_type;
   assign sel_addr  = grant ? d_rd_addr : i_rd_addr;
   assign next_cnt  = beat_cnt + 8'd1;
   assign req_beats = (sel_type == 3'b100) ? 8'(LINE_BEATS) : 8'd1;

   assign rd_req    = in_issue & sel_req;
   assign rd_type   = in_issue ? sel_type : 3'd0;
   assign rd_addr   = in_issue ? sel_addr : 32'd0;
   assign i_rd_rdy  = in_issue & ~grant & rd_rdy;
   assign d_rd_rdy  = in_issue &  grant & rd_rdy;

   assign i_ret_valid = in_wait & ~grant & ret_valid;
   assign i_ret_last  = in_wait & ~grant & ret_last;
   assign d_ret_valid = in_wait &  grant & ret_valid;
   assign d_ret_last  = in_wait &  grant & ret_last;
   assign i_ret_data  = ret_data;
   assign d_ret_data  = ret_data;

   assign busy = in_issue | in_wait;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b0;
         beat_cnt   <= 8'd0;
         exp_beats  <= 8'd0;
         proto_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ret_valid)
                  proto_err <= 1'b1;
               if (i_rd_req || d_rd_req) begin
                  grant <= pick_d;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (ret_valid)
                  proto_err <= 1'b1;
               // A request withdrawn before acceptance does not count as a turn.
               if (sel_req && rd_rdy) begin
                  exp_beats <= req_beats;
                  beat_cnt  <= 8'd0;
                  state     <= WAIT;
               end else if (!sel_req) begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (ret_valid) begin
                  beat_cnt <= next_cnt;
                  if (ret_last) begin
                     if (next_cnt != exp_beats)
                        proto_err <= 1'b1;
                     last_grant <= grant;
                     state      <= IDLE;
                  end else if (next_cnt >= exp_beats) begin
                     proto_err <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Scoreboard bench for cache_rd_arbiter: a round-robin instance drives the main scenarios,
// and a second instance with FIXED_PRIO=1 checks dcache priority.
module tb_cache_rd_arbiter;

   typedef struct packed {
      logic        port;
      logic        last;
      logic [31:0] data;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset;

   logic        i_rd_req, d_rd_req;
   logic [2:0]  i_rd_type, d_rd_type;
   logic [31:0] i_rd_addr, d_rd_addr;
   logic        i_rd_rdy, d_rd_rdy;
   logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
   logic [31:0] i_ret_data, d_ret_data;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy, ret_valid, ret_last;
   logic [31:0] ret_data;
   logic        busy, grant, proto_err;

   logic        f_i_rd_req, f_d_rd_req, f_rd_rdy, f_ret_valid, f_ret_last;
   logic        f_i_rd_rdy, f_d_rd_rdy;
   logic        f_i_ret_valid, f_i_ret_last, f_d_ret_valid, f_d_ret_last;
   logic [31:0] f_i_ret_data, f_d_ret_data;
   logic        f_rd_req;
   logic [2:0]  f_rd_type;
   logic [31:0] f_rd_addr;
   logic        f_busy, f_grant, f_proto_err;

   beat_t       sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int          i_rdy_cnt = 0;
   int          f_i_rdy_cnt = 0;

   always #5 clock = ~clock;

   cache_rd_arbiter #(.FIXED_PRIO(0), .LINE_BEATS(4)) dut (
      .clock(clock), .reset(reset),
      .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
      .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
      .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
      .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .busy(busy), .grant(grant), .proto_err(proto_err)
   );

   cache_rd_arbiter #(.FIXED_PRIO(1), .LINE_BEATS(4)) dut_fp (
      .clock(clock), .reset(reset),
      .i_rd_req(f_i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(f_i_rd_rdy),
      .i_ret_valid(f_i_ret_valid), .i_ret_last(f_i_ret_last), .i_ret_data(f_i_ret_data),
      .d_rd_req(f_d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(f_d_rd_rdy),
      .d_ret_valid(f_d_ret_valid), .d_ret_last(f_d_ret_last), .d_ret_data(f_d_ret_data),
      .rd_req(f_rd_req), .rd_type(f_rd_type), .rd_addr(f_rd_addr), .rd_rdy(f_rd_rdy),
      .ret_valid(f_ret_valid), .ret_last(f_ret_last), .ret_data(ret_data),
      .busy(f_busy), .grant(f_grant), .proto_err(f_proto_err)
   );

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic report_timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Return monitor: every beat the DUT hands to a cache must match the oldest expected beat.
   always @(negedge clock) begin
      if (i_rd_rdy) i_rdy_cnt++;
      if (f_i_rd_rdy) f_i_rdy_cnt++;
      if (reset && (i_ret_valid || d_ret_valid)) begin
         check_output("ret_valid_onehot", 64'(i_ret_valid & d_ret_valid), 64'd0);
         if (sb_q.size() == 0) begin
            report_timeout("unexpected_beat");
         end else begin
            beat_t act, exp_b;
            exp_b = sb_q.pop_front();
            act.port = d_ret_valid;
            act.last = d_ret_valid ? d_ret_last : i_ret_last;
            act.data = d_ret_valid ? d_ret_data : i_ret_data;
            check_output("ret_beat", 64'(act), 64'(exp_b));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic port, input logic [2:0] typ, input logic [31:0] addr);
      if (port) begin
         d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
      end else begin
         i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Bridge model: accept the pending request after rdy_delay cycles, then return nbeats beats.
   // abort_at >= 0 pulls reset low while that beat is on the bus.
   task automatic bridge_serve(input logic exp_port, input logic [31:0] exp_addr, input int rdy_delay,
                               input int nbeats, input logic [31:0] base, input int abort_at);
      int n = 0;
      @(negedge clock);
      while (!rd_req && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!rd_req) begin
         report_timeout("wait_rd_req");
         return;
      end
      check_output("grant", 64'(grant), 64'(exp_port));
      check_output("rd_addr", 64'(rd_addr), 64'(exp_addr));
      repeat (rdy_delay) tick();
      rd_rdy = 1'b1;
      #1;
      check_output("rd_rdy_route", 64'({i_rd_rdy, d_rd_rdy}), exp_port ? 64'd1 : 64'd2);
      tick();
      rd_rdy = 1'b0;
      if (exp_port) d_rd_req = 1'b0; else i_rd_req = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         ret_valid = 1'b1;
         ret_data  = base + 32'(k);
         if (k == abort_at) begin
            ret_last = 1'b0;
            reset    = 1'b0;
            #1;
            check_output("reset_outputs",
                         64'({rd_req, i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_last,
                              d_ret_valid, d_ret_last, busy, grant, proto_err}), 64'd0);
            tick();
            ret_valid = 1'b0;
            tick();
            reset = 1'b1;
            return;
         end
         ret_last = (k == nbeats - 1);
         sb_q.push_back('{exp_port, (k == nbeats - 1), base + 32'(k)});
         tick();
      end
      ret_valid = 1'b0;
      ret_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int i0;
      int n;
      reset = 1'b0;
      i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
      d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
      rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
      f_i_rd_req = 0; f_d_rd_req = 0; f_rd_rdy = 0; f_ret_valid = 0; f_ret_last = 0;
      tick();
      check_output("reset_ctrl", 64'({rd_req, i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid,
                                      busy, grant, proto_err}), 64'd0);
      check_output("reset_data", 64'({rd_type, rd_addr}), 64'd0);
      tick();
      reset = 1'b1;

      $display("[TB] single icache line read");
      i0 = i_rdy_cnt;
      apply_stimulus(1'b0, 3'b100, 32'h1000);
      bridge_serve(1'b0, 32'h1000, 2, 4, 32'hA0, -1);
      @(negedge clock);
      check_output("i_rdy_pulses", 64'(i_rdy_cnt - i0), 64'd1);
      check_output("line_proto_err", 64'(proto_err), 64'd0);
      check_output("line_idle", 64'(busy), 64'd0);
      check_output("line_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] tie after reset, round-robin, word read");
      tick();
      apply_reset();
      apply_stimulus(1'b1, 3'b010, 32'h2004);
      apply_stimulus(1'b0, 3'b100, 32'h1040);
      bridge_serve(1'b1, 32'h2004, 0, 1, 32'hDEADBEEF, -1);
      @(negedge clock);
      check_output("word_idle_next", 64'({busy, rd_req}), 64'd0);
      @(negedge clock);
      check_output("icache_issue_n2", 64'({rd_req, grant}), 64'd2);
      bridge_serve(1'b0, 32'h1040, 1, 4, 32'hB0, -1);
      apply_stimulus(1'b1, 3'b010, 32'h2008);
      apply_stimulus(1'b0, 3'b100, 32'h1080);
      bridge_serve(1'b1, 32'h2008, 0, 1, 32'h12345678, -1);
      bridge_serve(1'b0, 32'h1080, 0, 4, 32'hC0, -1);
      check_output("rr_proto_err", 64'(proto_err), 64'd0);

      $display("[TB] beat-count violation");
      apply_stimulus(1'b0, 3'b100, 32'h1100);
      bridge_serve(1'b0, 32'h1100, 0, 3, 32'hE0, -1);
      @(negedge clock);
      check_output("short_line_err", 64'(proto_err), 64'd1);
      check_output("short_line_idle", 64'(busy), 64'd0);
      repeat (3) @(negedge clock);
      check_output("proto_err_sticky", 64'(proto_err), 64'd1);

      $display("[TB] reset mid-WAIT");
      tick();
      apply_stimulus(1'b0, 3'b100, 32'h1200);
      bridge_serve(1'b0, 32'h1200, 0, 4, 32'hF0, 2);
      apply_stimulus(1'b0, 3'b100, 32'h1300);
      bridge_serve(1'b0, 32'h1300, 0, 4, 32'h50, -1);
      @(negedge clock);
      check_output("after_reset_err", 64'(proto_err), 64'd0);

      $display("[TB] fixed priority instance");
      tick();
      d_rd_type = 3'b010; d_rd_addr = 32'h3000;
      i_rd_type = 3'b100; i_rd_addr = 32'h1400;
      i0 = f_i_rdy_cnt;
      f_i_rd_req = 1'b1; f_d_rd_req = 1'b1; f_rd_rdy = 1'b1;
      for (int t = 0; t < 3; t++) begin
         n = 0;
         @(negedge clock);
         while (!f_rd_req && n < 20) begin
            @(negedge clock);
            n++;
         end
         if (!f_rd_req) begin
            report_timeout("fp_wait_rd_req");
            break;
         end
         check_output("fp_grant", 64'({f_grant, f_d_rd_rdy, f_i_rd_rdy}), 64'd6);
         check_output("fp_rd_addr", 64'(f_rd_addr), 64'h3000);
         tick();
         f_ret_valid = 1'b1; f_ret_last = 1'b1;
         tick();
         f_ret_valid = 1'b0; f_ret_last = 1'b0;
      end
      f_i_rd_req = 1'b0; f_d_rd_req = 1'b0; f_rd_rdy = 1'b0;
      @(negedge clock);
      check_output("fp_i_rdy_never", 64'(f_i_rdy_cnt - i0), 64'd0);
      check_output("fp_proto_err", 64'(f_proto_err), 64'd0);
      check_output("final_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
